// File: rtl/common_def.sv
// Shared reorder-buffer types: tag geometry, instruction kinds and the entry record.
package common_def;

  localparam int unsigned ROB_DEPTH = 8;
  localparam int unsigned IDX_W     = $clog2(ROB_DEPTH);
  localparam int unsigned TAG_W     = IDX_W + 1;

  // A set MSB marks a tag as "no instruction".
  localparam logic [TAG_W-1:0] TAG_INVALID = {1'b1, {IDX_W{1'b0}}};

  typedef enum logic [1:0] {
    KIND_ALU    = 2'd0,
    KIND_JUMP   = 2'd1,
    KIND_BRANCH = 2'd2
  } kind_e;

  typedef struct packed {
    logic        busy;
    logic        done;
    kind_e       kind;
    logic [4:0]  rd;
    logic [31:0] data;
    logic        redir;
    logic [31:0] next_pc;
  } rob_entry_t;

endpackage

// File: rtl/rob_wb_merge.sv
// Decodes the four writeback buses into per-entry update strobes.
// When several buses name the same entry only the highest-priority one lands.
module rob_wb_merge #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned IDX_W = $clog2(DEPTH),
  parameter int unsigned TAG_W = IDX_W + 1
) (
  input  logic [TAG_W-1:0] alu_target,
  input  logic [TAG_W-1:0] fwd_target,
  input  logic [TAG_W-1:0] jump_target,
  input  logic [TAG_W-1:0] br_target,
  input  logic [31:0]      alu_result,
  input  logic [31:0]      fwd_result,
  input  logic [31:0]      jump_ori_pc,
  input  logic [31:0]      jump_next_pc,
  input  logic [31:0]      br_next_pc,
  input  logic             br_cmp_res,
  output logic [DEPTH-1:0] wb_we_c,
  output logic [DEPTH-1:0] wb_data_we_c,
  output logic [DEPTH-1:0] wb_pc_we_c,
  output logic [DEPTH-1:0] wb_redir_c,
  output logic [31:0]      wb_data_c    [DEPTH],
  output logic [31:0]      wb_next_pc_c [DEPTH]
);

  function automatic logic hit(input logic [TAG_W-1:0] t, input int unsigned idx);
    return !t[TAG_W-1] && (t[IDX_W-1:0] == IDX_W'(idx));
  endfunction

  logic [31:0] jump_link;
  assign jump_link = jump_ori_pc + 32'd4;

  // Priority alu > fwd > jump > branch per entry.
  always_comb begin
    for (int i = 0; i < int'(DEPTH); i++) begin
      wb_we_c[i]      = 1'b0;
      wb_data_we_c[i] = 1'b0;
      wb_pc_we_c[i]   = 1'b0;
      wb_redir_c[i]   = 1'b0;
      wb_data_c[i]    = '0;
      wb_next_pc_c[i] = '0;
      if (hit(alu_target, i)) begin
        wb_we_c[i]      = 1'b1;
        wb_data_we_c[i] = 1'b1;
        wb_data_c[i]    = alu_result;
      end else if (hit(fwd_target, i)) begin
        wb_we_c[i]      = 1'b1;
        wb_data_we_c[i] = 1'b1;
        wb_data_c[i]    = fwd_result;
      end else if (hit(jump_target, i)) begin
        wb_we_c[i]      = 1'b1;
        wb_data_we_c[i] = 1'b1;
        wb_data_c[i]    = jump_link;
        wb_pc_we_c[i]   = 1'b1;
        wb_redir_c[i]   = 1'b1;
        wb_next_pc_c[i] = jump_next_pc;
      end else if (hit(br_target, i)) begin
        wb_we_c[i]      = 1'b1;
        wb_pc_we_c[i]   = 1'b1;
        wb_redir_c[i]   = br_cmp_res;
        wb_next_pc_c[i] = br_next_pc;
      end
    end
  end

endmodule

// File: rtl/rob.sv
// Reorder buffer: in-order tag allocation, writeback absorption, one in-order
// retire per cycle, and a registered flush/redirect on taken branches and jumps.
module rob #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned IDX_W = $clog2(DEPTH),
  parameter int unsigned TAG_W = IDX_W + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             alloc_valid,
  input  logic [1:0]       alloc_kind,
  input  logic [4:0]       alloc_rd,
  output logic             alloc_ready,
  output logic [TAG_W-1:0] alloc_tag,
  input  logic [TAG_W-1:0] alu_target,
  input  logic [TAG_W-1:0] fwd_target,
  input  logic [TAG_W-1:0] jump_target,
  input  logic [TAG_W-1:0] br_target,
  input  logic [31:0]      alu_result,
  input  logic [31:0]      fwd_result,
  input  logic [31:0]      jump_ori_pc,
  input  logic [31:0]      jump_next_pc,
  input  logic [31:0]      br_next_pc,
  input  logic             br_cmp_res,
  output logic             commit_valid,
  output logic             commit_we,
  output logic [4:0]       commit_rd,
  output logic [31:0]      commit_data,
  output logic [TAG_W-1:0] commit_tag,
  output logic             flush,
  output logic [31:0]      flush_pc
);
  import common_def::*;

  localparam int unsigned CNT_W = IDX_W + 1;
  localparam logic [TAG_W-1:0] TAG_INV = {1'b1, {IDX_W{1'b0}}};

  rob_entry_t       ent_q [DEPTH];
  rob_entry_t       ent_d [DEPTH];
  logic [IDX_W-1:0] head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             commit_valid_q, commit_valid_d, commit_we_q, commit_we_d;
  logic [4:0]       commit_rd_q, commit_rd_d;
  logic [31:0]      commit_data_q, commit_data_d, flush_pc_q, flush_pc_d;
  logic [TAG_W-1:0] commit_tag_q, commit_tag_d;
  logic             flush_q, flush_d;

  logic [DEPTH-1:0] wb_we_c, wb_data_we_c, wb_pc_we_c, wb_redir_c;
  logic [31:0]      wb_data_c    [DEPTH];
  logic [31:0]      wb_next_pc_c [DEPTH];

  rob_wb_merge #(.DEPTH(DEPTH), .IDX_W(IDX_W), .TAG_W(TAG_W)) u_wb_merge (
    .alu_target   (alu_target),
    .fwd_target   (fwd_target),
    .jump_target  (jump_target),
    .br_target    (br_target),
    .alu_result   (alu_result),
    .fwd_result   (fwd_result),
    .jump_ori_pc  (jump_ori_pc),
    .jump_next_pc (jump_next_pc),
    .br_next_pc   (br_next_pc),
    .br_cmp_res   (br_cmp_res),
    .wb_we_c      (wb_we_c),
    .wb_data_we_c (wb_data_we_c),
    .wb_pc_we_c   (wb_pc_we_c),
    .wb_redir_c   (wb_redir_c),
    .wb_data_c    (wb_data_c),
    .wb_next_pc_c (wb_next_pc_c)
  );

  rob_entry_t head_e;
  logic       retire_c, flush_now_c, alloc_fire_c;

  assign head_e       = ent_q[head_q];
  assign retire_c     = head_e.busy && head_e.done;
  assign flush_now_c  = retire_c && head_e.redir;
  assign alloc_ready  = (count_q < CNT_W'(DEPTH)) && !flush_now_c;
  assign alloc_tag    = {1'b0, tail_q};
  assign alloc_fire_c = alloc_valid && alloc_ready;

  always_comb begin
    ent_d          = ent_q;
    head_d         = head_q;
    tail_d         = tail_q;
    count_d        = count_q;
    commit_valid_d = 1'b0;
    commit_we_d    = 1'b0;
    commit_rd_d    = commit_rd_q;
    commit_data_d  = commit_data_q;
    commit_tag_d   = commit_tag_q;
    flush_d        = 1'b0;
    flush_pc_d     = flush_pc_q;

    // Writebacks only land on live entries.
    for (int i = 0; i < int'(DEPTH); i++) begin
      if (wb_we_c[i] && ent_q[i].busy) begin
        ent_d[i].done = 1'b1;
        if (wb_data_we_c[i]) ent_d[i].data = wb_data_c[i];
        if (wb_pc_we_c[i]) begin
          ent_d[i].redir   = wb_redir_c[i];
          ent_d[i].next_pc = wb_next_pc_c[i];
        end
      end
    end

    if (retire_c) begin
      commit_valid_d = 1'b1;
      commit_we_d    = (head_e.kind != KIND_BRANCH) && (head_e.rd != 5'd0);
      commit_rd_d    = head_e.rd;
      commit_data_d  = head_e.data;
      commit_tag_d   = {1'b0, head_q};
      ent_d[head_q]  = '0;
      head_d         = head_q + IDX_W'(1);
    end

    if (alloc_fire_c) begin
      ent_d[tail_q] = '{busy: 1'b1, done: 1'b0, kind: kind_e'(alloc_kind), rd: alloc_rd,
                        data: 32'd0, redir: 1'b0, next_pc: 32'd0};
      tail_d        = tail_q + IDX_W'(1);
    end

    case ({alloc_fire_c, retire_c})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase

    // Redirect squashes everything younger, including this cycle's traffic.
    if (flush_now_c) begin
      for (int i = 0; i < int'(DEPTH); i++) ent_d[i] = '0;
      head_d     = '0;
      tail_d     = '0;
      count_d    = '0;
      flush_d    = 1'b1;
      flush_pc_d = head_e.next_pc;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(DEPTH); i++) ent_q[i] <= '0;
      head_q         <= '0;
      tail_q         <= '0;
      count_q        <= '0;
      commit_valid_q <= 1'b0;
      commit_we_q    <= 1'b0;
      commit_rd_q    <= '0;
      commit_data_q  <= '0;
      commit_tag_q   <= TAG_INV;
      flush_q        <= 1'b0;
      flush_pc_q     <= '0;
    end else begin
      ent_q          <= ent_d;
      head_q         <= head_d;
      tail_q         <= tail_d;
      count_q        <= count_d;
      commit_valid_q <= commit_valid_d;
      commit_we_q    <= commit_we_d;
      commit_rd_q    <= commit_rd_d;
      commit_data_q  <= commit_data_d;
      commit_tag_q   <= commit_tag_d;
      flush_q        <= flush_d;
      flush_pc_q     <= flush_pc_d;
    end
  end

  assign commit_valid = commit_valid_q;
  assign commit_we    = commit_we_q;
  assign commit_rd    = commit_rd_q;
  assign commit_data  = commit_data_q;
  assign commit_tag   = commit_tag_q;
  assign flush        = flush_q;
  assign flush_pc     = flush_pc_q;

endmodule

// File: tb/tb_rob.sv
// Bench for rob: an in-order queue model checked every cycle, plus directed
// scenarios with literal expectations.
module tb_rob;
  import common_def::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        alloc_valid;
  logic [1:0]  alloc_kind;
  logic [4:0]  alloc_rd;
  logic        alloc_ready;
  logic [3:0]  alloc_tag;
  logic [3:0]  alu_target, fwd_target, jump_target, br_target;
  logic [31:0] alu_result, fwd_result, jump_ori_pc, jump_next_pc, br_next_pc;
  logic        br_cmp_res;
  logic        commit_valid, commit_we, flush;
  logic [4:0]  commit_rd;
  logic [31:0] commit_data, flush_pc;
  logic [3:0]  commit_tag;

  rob dut (
    .clk(clk), .rst(rst),
    .alloc_valid(alloc_valid), .alloc_kind(alloc_kind), .alloc_rd(alloc_rd),
    .alloc_ready(alloc_ready), .alloc_tag(alloc_tag),
    .alu_target(alu_target), .fwd_target(fwd_target),
    .jump_target(jump_target), .br_target(br_target),
    .alu_result(alu_result), .fwd_result(fwd_result),
    .jump_ori_pc(jump_ori_pc), .jump_next_pc(jump_next_pc),
    .br_next_pc(br_next_pc), .br_cmp_res(br_cmp_res),
    .commit_valid(commit_valid), .commit_we(commit_we), .commit_rd(commit_rd),
    .commit_data(commit_data), .commit_tag(commit_tag),
    .flush(flush), .flush_pc(flush_pc)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=0x%0h required=0x%0h @%0t", nm, act, exp, $time);
    end
  endtask

  // Model: live instructions held oldest-first in a queue.
  typedef struct {
    int          tag;
    logic [1:0]  kind;
    logic [4:0]  rd;
    bit          done;
    logic [31:0] data;
    bit          redir;
    logic [31:0] npc;
  } ment_t;

  ment_t       mq[$];
  int          ntag = 0;
  bit          m_cv = 0, m_we = 0, m_fl = 0;
  logic [4:0]  m_rd;
  logic [31:0] m_data, m_fpc;
  logic [3:0]  m_tag;
  logic [4:0]  clog_rd[$];
  logic [31:0] clog_data[$];

  function automatic bit hit(input logic [3:0] t, input int tag);
    return (t[3] == 1'b0) && (int'(t[2:0]) == tag);
  endfunction

  initial forever begin
    @(posedge clk);
    if (rst) begin
      mq.delete();
      ntag = 0;
      m_cv = 0; m_we = 0; m_fl = 0;
    end else begin
      bit full, ret, fl;
      full = (mq.size() == 8);
      ret  = (mq.size() > 0) && mq[0].done;
      fl   = ret && mq[0].redir;
      m_cv = ret;
      m_we = 0;
      m_fl = fl;
      if (ret) begin
        m_tag  = {1'b0, 3'(mq[0].tag)};
        m_rd   = mq[0].rd;
        m_data = mq[0].data;
        m_we   = (mq[0].kind != KIND_BRANCH) && (mq[0].rd != 5'd0);
        if (fl) m_fpc = mq[0].npc;
        void'(mq.pop_front());
      end
      if (fl) begin
        mq.delete();
        ntag = 0;
      end else begin
        for (int k = 0; k < mq.size(); k++) begin
          if (hit(alu_target, mq[k].tag)) begin
            mq[k].data = alu_result; mq[k].done = 1;
          end else if (hit(fwd_target, mq[k].tag)) begin
            mq[k].data = fwd_result; mq[k].done = 1;
          end else if (hit(jump_target, mq[k].tag)) begin
            mq[k].data = jump_ori_pc + 32'd4; mq[k].redir = 1;
            mq[k].npc = jump_next_pc; mq[k].done = 1;
          end else if (hit(br_target, mq[k].tag)) begin
            mq[k].redir = br_cmp_res; mq[k].npc = br_next_pc; mq[k].done = 1;
          end
        end
        if (alloc_valid && !full) begin
          mq.push_back('{tag: ntag, kind: alloc_kind, rd: alloc_rd, done: 0,
                         data: 32'd0, redir: 0, npc: 32'd0});
          ntag = (ntag + 1) % 8;
        end
      end
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  initial forever begin
    @(negedge clk);
    if (chk_en) begin
      bit exp_ready;
      exp_ready = (mq.size() < 8) && !((mq.size() > 0) && mq[0].done && mq[0].redir);
      chk("m_alloc_ready", alloc_ready, exp_ready);
      chk("m_alloc_tag", alloc_tag, {1'b0, 3'(ntag)});
      chk("m_commit_valid", commit_valid, m_cv);
      chk("m_flush", flush, m_fl);
      if (m_cv) begin
        chk("m_commit_we", commit_we, m_we);
        chk("m_commit_rd", commit_rd, m_rd);
        chk("m_commit_data", commit_data, m_data);
        chk("m_commit_tag", commit_tag, m_tag);
      end
      if (m_fl) chk("m_flush_pc", flush_pc, m_fpc);
      if (commit_valid) begin
        clog_rd.push_back(commit_rd);
        clog_data.push_back(commit_data);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    alloc_valid = 0; alloc_kind = 2'd0; alloc_rd = 5'd0;
    alu_target = TAG_INVALID; fwd_target = TAG_INVALID;
    jump_target = TAG_INVALID; br_target = TAG_INVALID;
    br_cmp_res = 0;
  endtask

  task automatic do_reset();
    idle();
    rst = 1; tick(); rst = 0;
  endtask

  task automatic alloc(input logic [1:0] k, input logic [4:0] rd);
    alloc_valid = 1; alloc_kind = k; alloc_rd = rd;
    tick();
    alloc_valid = 0;
  endtask

  task automatic wb_alu(input logic [3:0] t, input logic [31:0] v);
    alu_target = t; alu_result = v;
    tick();
    alu_target = TAG_INVALID;
  endtask

  task automatic wait_flush(input string nm);
    int n;
    n = 0;
    while (!flush && n < 10) begin tick(); n++; end
    if (!flush) chk(nm, 32'(flush), 32'd1);
  endtask

  task automatic wait_commit(input string nm);
    int n;
    n = 0;
    while (!commit_valid && n < 10) begin tick(); n++; end
    if (!commit_valid) chk(nm, 32'(commit_valid), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    alu_result = '0; fwd_result = '0; jump_ori_pc = '0; jump_next_pc = '0; br_next_pc = '0;
    idle();
    rst = 1; tick(); tick(); rst = 0;
    chk_en = 1;

    // Reset state.
    chk("rst_commit_valid", commit_valid, 0);
    chk("rst_commit_tag", commit_tag, 32'h8);
    chk("rst_flush", flush, 0);
    chk("rst_alloc_ready", alloc_ready, 1);
    chk("rst_alloc_tag", alloc_tag, 0);

    // Out-of-order writeback, in-order commit.
    clog_rd.delete(); clog_data.delete();
    for (int i = 0; i < 3; i++) begin
      chk("seq_alloc_tag", alloc_tag, 32'(i));
      alloc(KIND_ALU, 5'(i + 1));
    end
    wb_alu(4'd2, 32'h33);
    wb_alu(4'd0, 32'h11);
    wb_alu(4'd1, 32'h22);
    repeat (6) tick();
    chk("order_count", clog_rd.size(), 3);
    if (clog_rd.size() == 3) begin
      chk("order_rd0", clog_rd[0], 1);   chk("order_d0", clog_data[0], 32'h11);
      chk("order_rd1", clog_rd[1], 2);   chk("order_d1", clog_data[1], 32'h22);
      chk("order_rd2", clog_rd[2], 3);   chk("order_d2", clog_data[2], 32'h33);
    end

    // Full, then retire one and wrap to tag 0.
    do_reset();
    alloc_valid = 1; alloc_kind = KIND_ALU; alloc_rd = 5'd5;
    repeat (8) tick();
    chk("full_ready", alloc_ready, 0);
    alu_target = 4'd0; alu_result = 32'h5;
    tick();
    alu_target = TAG_INVALID;
    begin
      int n;
      n = 0;
      while (!alloc_ready && n < 6) begin tick(); n++; end
    end
    chk("wrap_ready", alloc_ready, 1);
    chk("wrap_tag", alloc_tag, 0);
    tick();
    alloc_valid = 0;
    chk("refull_ready", alloc_ready, 0);

    // Taken branch at head with younger work in flight.
    do_reset();
    alloc(KIND_BRANCH, 5'd0);
    alloc(KIND_ALU, 5'd1);
    alloc(KIND_ALU, 5'd2);
    alloc(KIND_ALU, 5'd3);
    wb_alu(4'd1, 32'h77);
    br_target = 4'd0; br_cmp_res = 1; br_next_pc = 32'h200;
    tick();
    idle();
    clog_rd.delete(); clog_data.delete();
    wait_flush("br_flush_wait");
    chk("br_commit_valid", commit_valid, 1);
    chk("br_commit_we", commit_we, 0);
    chk("br_flush_pc", flush_pc, 32'h200);
    chk("br_after_tag", alloc_tag, 0);
    repeat (4) tick();
    chk("br_younger_squashed", clog_rd.size(), 1);

    // Jump with rd=1 then rd=0.
    do_reset();
    alloc(KIND_JUMP, 5'd1);
    jump_target = 4'd0; jump_ori_pc = 32'h100; jump_next_pc = 32'h400;
    tick();
    idle();
    wait_flush("jmp_flush_wait");
    chk("jmp_commit_data", commit_data, 32'h104);
    chk("jmp_commit_we", commit_we, 1);
    chk("jmp_flush_pc", flush_pc, 32'h400);
    tick();
    alloc(KIND_JUMP, 5'd0);
    jump_target = 4'd0;
    tick();
    idle();
    wait_flush("jmp0_flush_wait");
    chk("jmp0_commit_valid", commit_valid, 1);
    chk("jmp0_commit_we", commit_we, 0);

    // Stray writeback, then alu/fwd collision.
    do_reset();
    clog_rd.delete(); clog_data.delete();
    wb_alu(4'd5, 32'h55);
    repeat (4) tick();
    chk("stray_no_commit", clog_rd.size(), 0);
    chk("stray_tag", alloc_tag, 0);
    alloc(KIND_ALU, 5'd7);
    alu_target = 4'd0; alu_result = 32'hA;
    fwd_target = 4'd0; fwd_result = 32'hB;
    tick();
    idle();
    wait_commit("prio_commit_wait");
    chk("prio_data", commit_data, 32'hA);
    chk("prio_rd", commit_rd, 7);

    // Reset while a flush is pending and four entries are busy.
    do_reset();
    alloc(KIND_ALU, 5'd9);
    wb_alu(4'd0, 32'h99);
    wait_commit("pre_commit_wait");
    chk("pre_commit_rd", commit_rd, 9);
    alloc(KIND_JUMP, 5'd1);
    alloc(KIND_ALU, 5'd2);
    alloc(KIND_ALU, 5'd3);
    alloc(KIND_ALU, 5'd4);
    jump_target = 4'd1; jump_ori_pc = 32'h300; jump_next_pc = 32'h500;
    tick();
    idle();
    rst = 1; tick(); rst = 0;
    chk("mid_commit_valid", commit_valid, 0);
    chk("mid_commit_we", commit_we, 0);
    chk("mid_commit_rd", commit_rd, 0);
    chk("mid_commit_data", commit_data, 0);
    chk("mid_commit_tag", commit_tag, 32'h8);
    chk("mid_flush", flush, 0);
    chk("mid_flush_pc", flush_pc, 0);
    chk("mid_alloc_tag", alloc_tag, 0);
    chk("mid_alloc_ready", alloc_ready, 1);
    repeat (4) tick();

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
